lfsr_encrypt: RTL and testbench

Transmit-side counterpart of the lab 5 LFSR decrypter. On a `start` pulse it reads a plaintext message from data memory and writes the encrypted stream back into the same memory. The stream is a fixed preamble of `0x5F` underscore characters followed by the message, with every byte XORed with the keystream of a 6-bit maximal-length LFSR. The caller supplies the tap index and seed. The block drives the existing `dat_mem` ports directly and sits beside the decrypter in the lab top level, so the two can run as a round trip.

---
 rtl/lfsr_pkg.sv | 48 ++++
 rtl/lfsr6b.sv | 22 ++
 rtl/lfsr_encrypt.sv | 154 +++++++++++++++
 tb/tb_lfsr_encrypt.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants, types and helpers for the LFSR encrypter slice.
// Holds the tap table, preamble byte, FSM encoding and the LFSR step function.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 6;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned N_TAPS = 6;

    localparam logic [LFSR_W-1:0] LFSR_TAPS [N_TAPS] = '{
        6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39
    };

    localparam logic [BYTE_W-1:0] PREAMBLE_CHAR = 8'h5F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_MSG  = 2'd2,
        ST_DONE = 2'd3
    } enc_state_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } mem_wr_t;

    // Shift left, feedback is the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] state,
        input logic [LFSR_W-1:0] taps
    );
        return {state[LFSR_W-2:0], ^(state & taps)};
    endfunction

    // Out-of-range selectors map to zero taps; callers reject them separately.
    function automatic logic [LFSR_W-1:0] tap_lookup(input logic [SEL_W-1:0] sel);
        logic [LFSR_W-1:0] t;
        t = '0;
        for (int i = 0; i < int'(N_TAPS); i++) begin
            if (sel == SEL_W'(i)) t = LFSR_TAPS[i];
        end
        return t;
    endfunction

endpackage

// File: rtl/lfsr6b.sv
// 6-bit Fibonacci LFSR shared with the lab 5 decrypter.
// init loads the start value; en advances one step per clock.
module lfsr6b
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              init,
    input  logic [LFSR_W-1:0] taps,
    input  logic [LFSR_W-1:0] start,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (init) begin
            state <= start;
        end else if (en) begin
            state <= lfsr_next(state, taps);
        end
    end

endmodule

// File: rtl/lfsr_encrypt.sv
// Encrypts a plaintext window into a preamble-prefixed ciphertext window of
// the same memory, one byte per clock, using an LFSR keystream.
module lfsr_encrypt
    import lfsr_pkg::*;
#(
    parameter int unsigned        PRE_LEN = 7,
    parameter int unsigned        MSG_LEN = 64,
    parameter logic [ADDR_W-1:0]  RD_BASE = 8'd0,
    parameter logic [ADDR_W-1:0]  WR_BASE = 8'd64
)(
    input  logic              clk,
    input  logic              init,
    input  logic              start,
    input  logic [SEL_W-1:0]  tap_sel,
    input  logic [LFSR_W-1:0] seed,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned       CNT_W    = ADDR_W;
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0]  MSG_LAST = CNT_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0]  PRE_OFS  = CNT_W'(PRE_LEN);

    enc_state_t        state_q;
    enc_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [LFSR_W-1:0] taps_q;
    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-1:0] lfsr_load_val;
    logic              lfsr_load;
    logic              bad_q;
    logic              accept_c;
    logic              params_ok_c;
    logic              load_c;
    logic              last_c;
    logic [BYTE_W-1:0] key_c;
    mem_wr_t           wr_c;

    assign accept_c    = (state_q == ST_IDLE) && start;
    assign params_ok_c = (tap_sel < SEL_W'(N_TAPS)) && (seed != '0);
    assign load_c      = accept_c && params_ok_c;
    assign last_c      = (cnt_q == MSG_LAST);
    assign key_c       = {2'b00, lfsr_state};

    // Reset also loads zero so the keystream register has a defined value.
    assign lfsr_load     = load_c || init;
    assign lfsr_load_val = load_c ? seed : '0;

    lfsr6b u_lfsr (
        .clk   (clk),
        .en    (busy),
        .init  (lfsr_load),
        .taps  (taps_q),
        .start (lfsr_load_val),
        .state (lfsr_state)
    );

    // State register.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = params_ok_c ? ST_PRE : ST_DONE;
            end
            ST_PRE: begin
                if (last_c) begin
                    state_d = ST_DONE;
                end else if (cnt_q == PRE_LAST) begin
                    state_d = ST_MSG;
                end
            end
            ST_MSG: begin
                if (last_c) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory port drive; the read is combinational so the write data follows it.
    always_comb begin
        wr_c      = '0;
        mem_raddr = '0;
        case (state_q)
            ST_PRE: begin
                wr_c.en   = 1'b1;
                wr_c.addr = WR_BASE + cnt_q;
                wr_c.data = PREAMBLE_CHAR ^ key_c;
            end
            ST_MSG: begin
                mem_raddr = RD_BASE + (cnt_q - PRE_OFS);
                wr_c.en   = 1'b1;
                wr_c.addr = WR_BASE + cnt_q;
                wr_c.data = mem_rdata ^ key_c;
            end
            default: ;
        endcase
    end

    assign mem_wr_en = wr_c.en;
    assign mem_waddr = wr_c.addr;
    assign mem_wdata = wr_c.data;

    // Counter, latched taps and status flags.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            cnt_q  <= '0;
            taps_q <= '0;
            bad_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        cnt_q <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                        bad_q <= !params_ok_c;
                        busy  <= params_ok_c;
                        if (params_ok_c) taps_q <= tap_lookup(tap_sel);
                    end
                end
                ST_PRE, ST_MSG: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_c) busy <= 1'b0;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    error <= bad_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_encrypt.sv
// Self-checking bench for lfsr_encrypt: behavioural write-stream model plus
// directed scenarios with hand-computed ciphertext bytes.
module tb_lfsr_encrypt;

    localparam int PRE_LEN = 7;
    localparam int MSG_LEN = 64;
    localparam int RD_BASE = 0;
    localparam int WR_BASE = 64;
    localparam int NPLAIN  = MSG_LEN - PRE_LEN;

    logic       clk = 1'b0;
    logic       init;
    logic       start;
    logic [2:0] tap_sel;
    logic [5:0] seed;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       error;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;
    int lat;

    logic [7:0] mem   [256];
    logic [7:0] plain [NPLAIN];

    always #5 clk = ~clk;

    lfsr_encrypt dut (
        .clk       (clk),
        .init      (init),
        .start     (start),
        .tap_sel   (tap_sel),
        .seed      (seed),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    assign mem_rdata = mem[mem_raddr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_waddr] = mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [5:0] tap_value(input int idx);
        case (idx)
            0: return 6'h21;
            1: return 6'h2D;
            2: return 6'h30;
            3: return 6'h33;
            4: return 6'h36;
            5: return 6'h39;
            default: return 6'h00;
        endcase
    endfunction

    // Doubling mod 64 plus the parity of the tapped bits.
    function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] t);
        int v;
        v = ((int'(s) * 2) % 64) + ($countones(s & t) % 2);
        return 6'(v);
    endfunction

    function automatic logic [7:0] key_byte(input int tap_idx, input logic [5:0] s0, input int n);
        logic [5:0] s;
        s = s0;
        for (int i = 0; i < n; i++) s = lfsr_step(s, tap_value(tap_idx));
        return {2'b00, s};
    endfunction

    int         m_pos = -1;
    logic       m_fin = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    logic       m_bad = 1'b0;
    logic [7:0] m_ks [MSG_LEN];

    always @(posedge clk or posedge init) begin
        if (init) begin
            m_pos  = -1;
            m_fin  = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_bad  = 1'b0;
        end else if (m_fin) begin
            m_fin  = 1'b0;
            m_done = 1'b1;
            m_err  = m_bad;
        end else if (m_pos >= 0) begin
            m_pos = m_pos + 1;
            if (m_pos == MSG_LEN) begin
                m_pos = -1;
                m_fin = 1'b1;
            end
        end else if (start) begin
            m_done = 1'b0;
            m_err  = 1'b0;
            m_bad  = (int'(tap_sel) > 5) || (seed == 6'd0);
            if (m_bad) begin
                m_fin = 1'b1;
            end else begin
                for (int i = 0; i < MSG_LEN; i++) m_ks[i] = key_byte(int'(tap_sel), seed, i);
                m_pos = 0;
            end
        end
    end

    logic       e_en;
    logic [7:0] e_wa, e_wd, e_ra;

    always @(negedge clk) begin
        e_en = (m_pos >= 0);
        e_wa = 8'h00;
        e_wd = 8'h00;
        e_ra = 8'h00;
        if (e_en) begin
            e_wa = 8'(WR_BASE + m_pos);
            if (m_pos < PRE_LEN) begin
                e_wd = 8'h5F ^ m_ks[m_pos];
            end else begin
                e_ra = 8'(RD_BASE + m_pos - PRE_LEN);
                e_wd = plain[m_pos - PRE_LEN] ^ m_ks[m_pos];
            end
        end
        check("cyc_wr_en", 32'(mem_wr_en), 32'(e_en));
        check("cyc_waddr", 32'(mem_waddr), 32'(e_wa));
        check("cyc_wdata", 32'(mem_wdata), 32'(e_wd));
        check("cyc_raddr", 32'(mem_raddr), 32'(e_ra));
        check("cyc_busy",  32'(busy),      32'(e_en));
        check("cyc_done",  32'(done),      32'(m_done));
        check("cyc_error", 32'(error),     32'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_plain(input int mode);
        for (int i = 0; i < NPLAIN; i++) begin
            plain[i] = (mode == 0) ? 8'h41 : 8'($urandom_range(32, 126));
            mem[RD_BASE + i] = plain[i];
        end
    endtask

    task automatic do_start(input logic [2:0] t, input logic [5:0] s);
        @(negedge clk);
        tap_sel = t;
        seed    = s;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles = cycles + 1;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_image(input int t, input logic [5:0] s);
        logic [7:0] exp;
        for (int i = 0; i < MSG_LEN; i++) begin
            exp = ((i < PRE_LEN) ? 8'h5F : plain[i - PRE_LEN]) ^ key_byte(t, s, i);
            check($sformatf("img[%0d]", WR_BASE + i), 32'(mem[WR_BASE + i]), 32'(exp));
        end
    endtask

    task automatic round_trip(input int t);
        logic [5:0] s;
        logic [5:0] sg;
        logic [7:0] dec;
        int         found;
        logic       ok;
        s = 6'($urandom_range(1, 63));
        load_plain(1);
        wr_count = 0;
        do_start(3'(t), s);
        wait_done(200, lat);
        check("rt_writes", 32'(wr_count), 32'(MSG_LEN));
        sg = 6'(mem[WR_BASE] ^ 8'h5F);
        found = -1;
        for (int c = 0; c < 6; c++) begin
            ok = 1'b1;
            for (int i = 0; i < MSG_LEN; i++) begin
                dec = mem[WR_BASE + i] ^ key_byte(c, sg, i);
                if (i < PRE_LEN) begin
                    if (dec != 8'h5F) ok = 1'b0;
                end else if (dec != plain[i - PRE_LEN]) begin
                    ok = 1'b0;
                end
            end
            if (ok && found < 0) found = c;
        end
        check("rt_seed", 32'(sg), 32'(s));
        check("rt_tap", 32'(found), 32'(t));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        init    = 1'b1;
        start   = 1'b0;
        tap_sel = 3'd0;
        seed    = 6'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        load_plain(0);

        #12;
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_raddr", 32'(mem_raddr), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_error", 32'(error),     32'd0);
        @(negedge clk);
        init = 1'b0;

        // Preamble and message body with tap 0, seed 1.
        wr_count = 0;
        do_start(3'd0, 6'h01);
        wait_done(200, lat);
        check("done_latency", 32'(lat), 32'd65);
        check("pre_writes", 32'(wr_count), 32'(MSG_LEN));
        check("mem64", 32'(mem[64]), 32'h5E);
        check("mem65", 32'(mem[65]), 32'h5C);
        check("mem66", 32'(mem[66]), 32'h58);
        check("mem67", 32'(mem[67]), 32'h50);
        check("mem70", 32'(mem[70]), 32'h61);
        check("mem71", 32'(mem[71]), 32'h7C);
        for (int i = 0; i < NPLAIN; i++) begin
            check($sformatf("body[%0d]", 71 + i), 32'(mem[71 + i]), 32'(8'h41 ^ key_byte(0, 6'h01, 7 + i)));
            check($sformatf("body_top[%0d]", 71 + i), 32'(mem[71 + i][7:6]), 32'd1);
        end

        // Invalid parameters: zero seed, then out-of-range tap index.
        wr_count = 0;
        do_start(3'd0, 6'h00);
        check("bad_seed_done0", 32'(done), 32'd0);
        @(negedge clk);
        check("bad_seed_error", 32'(error), 32'd1);
        check("bad_seed_done",  32'(done),  32'd1);
        do_start(3'd6, 6'h01);
        check("bad_tap_err0", 32'(error), 32'd0);
        @(negedge clk);
        check("bad_tap_error", 32'(error), 32'd1);
        check("bad_tap_done",  32'(done),  32'd1);
        repeat (3) @(negedge clk);
        check("bad_writes", 32'(wr_count), 32'd0);

        // Reset during message cycle 20, then a clean rerun.
        do_start(3'd1, 6'h2A);
        repeat (PRE_LEN + 20) @(posedge clk);
        #1;
        check("mid_wr_en_pre", 32'(mem_wr_en), 32'd1);
        check("mid_waddr_pre", 32'(mem_waddr), 32'(WR_BASE + PRE_LEN + 20));
        #1;
        init = 1'b1;
        #1;
        check("mid_wr_en", 32'(mem_wr_en), 32'd0);
        check("mid_waddr", 32'(mem_waddr), 32'd0);
        check("mid_wdata", 32'(mem_wdata), 32'd0);
        check("mid_raddr", 32'(mem_raddr), 32'd0);
        check("mid_busy",  32'(busy),      32'd0);
        check("mid_done",  32'(done),      32'd0);
        check("mid_error", 32'(error),     32'd0);
        @(negedge clk);
        init = 1'b0;
        wr_count = 0;
        do_start(3'd2, 6'h15);
        wait_done(200, lat);
        check("rerun_latency", 32'(lat), 32'd65);
        check("rerun_writes", 32'(wr_count), 32'(MSG_LEN));
        check_image(2, 6'h15);

        // Start pulses during a run must be ignored.
        wr_count = 0;
        do_start(3'd3, 6'h2B);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (36) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, lat);
        repeat (3) @(negedge clk);
        check("busy_start_writes", 32'(wr_count), 32'(MSG_LEN));
        check_image(3, 6'h2B);

        // Round trip across every tap index.
        for (int t = 0; t < 6; t++) round_trip(t);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
